// File: rtl/async_fifo_mc_bank.sv
// rtl/async_fifo_mc_bank.sv - bank of NCH independent single-clock FIFOs with level, thresholds and sticky errors
module async_fifo_mc_bank #(
    parameter int DATA_SIZE = 12,
    parameter int ADDR_SIZE = 4,
    parameter int NCH       = 4,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input  logic                         rclk,
    input  logic                         wrst,
    input  logic [NCH-1:0]               winc,
    input  logic [NCH*DATA_SIZE-1:0]     wData,
    input  logic [NCH-1:0]               rinc,
    output logic [NCH*DATA_SIZE-1:0]     rData,
    output logic [NCH-1:0]               wFull,
    output logic [NCH-1:0]               rEmpty,
    output logic [NCH-1:0]               aFull,
    output logic [NCH-1:0]               aEmpty,
    output logic [NCH*(ADDR_SIZE+1)-1:0] level,
    output logic [NCH-1:0]               ovf,
    output logic [NCH-1:0]               udf,
    input  logic                         err_clr
);
    localparam int DEPTH = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] AFULL_L  = AFULL_TH[ADDR_SIZE:0];
    localparam logic [ADDR_SIZE:0] AEMPTY_L = AEMPTY_TH[ADDR_SIZE:0];

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [ADDR_SIZE:0]   r_wptr;
        logic [ADDR_SIZE:0]   r_rptr;
        logic [ADDR_SIZE:0]   r_level;
        logic                 r_ovf;
        logic                 r_udf;
        logic [DATA_SIZE-1:0] r_mem [DEPTH];
        logic                 w_full;
        logic                 w_empty;
        logic                 w_push_ok;
        logic                 w_pop_ok;
        logic [DATA_SIZE-1:0] w_head;

        // Wrap bit distinguishes full from empty when the addresses coincide.
        assign w_full    = (r_wptr[ADDR_SIZE-1:0] == r_rptr[ADDR_SIZE-1:0]) &&
                           (r_wptr[ADDR_SIZE] != r_rptr[ADDR_SIZE]);
        assign w_empty   = (r_wptr == r_rptr);
        assign w_push_ok = winc[c] & ~w_full;
        assign w_pop_ok  = rinc[c] & ~w_empty;
        assign w_head    = r_mem[r_rptr[ADDR_SIZE-1:0]];

        always_ff @(posedge rclk or negedge wrst) begin
            if (!wrst) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_level <= '0;
                r_ovf   <= 1'b0;
                r_udf   <= 1'b0;
            end else begin
                if (w_push_ok) r_wptr <= r_wptr + 1'b1;
                if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
                if (w_push_ok && !w_pop_ok)      r_level <= r_level + 1'b1;
                else if (!w_push_ok && w_pop_ok) r_level <= r_level - 1'b1;
                // A new rejection takes priority over a clear in the same cycle.
                if (winc[c] && w_full)  r_ovf <= 1'b1;
                else if (err_clr)       r_ovf <= 1'b0;
                if (rinc[c] && w_empty) r_udf <= 1'b1;
                else if (err_clr)       r_udf <= 1'b0;
            end
        end

        always_ff @(posedge rclk) begin
            if (wrst && w_push_ok) r_mem[r_wptr[ADDR_SIZE-1:0]] <= wData[c*DATA_SIZE +: DATA_SIZE];
        end

        if (FWFT != 0) begin : g_fwft
            assign rData[c*DATA_SIZE +: DATA_SIZE] = w_empty ? '0 : w_head;
        end else begin : g_std
            logic [DATA_SIZE-1:0] r_rdata;
            always_ff @(posedge rclk or negedge wrst) begin
                if (!wrst)         r_rdata <= '0;
                else if (w_pop_ok) r_rdata <= w_head;
            end
            assign rData[c*DATA_SIZE +: DATA_SIZE] = r_rdata;
        end

        assign wFull[c]  = w_full;
        assign rEmpty[c] = w_empty;
        assign aFull[c]  = (r_level >= AFULL_L);
        assign aEmpty[c] = (r_level <= AEMPTY_L);
        assign level[c*(ADDR_SIZE+1) +: ADDR_SIZE+1] = r_level;
        assign ovf[c] = r_ovf;
        assign udf[c] = r_udf;
    end
endmodule

// File: tb/tb_async_fifo_mc_bank.sv
// tb/tb_async_fifo_mc_bank.sv - scoreboard bench for async_fifo_mc_bank, standard and FWFT instances
module tb_async_fifo_mc_bank;
    localparam int DW = 12;
    localparam int AW = 2;
    localparam int DEPTH = 4;
    localparam int NC = 2;
    localparam int AF = 3;
    localparam int AE = 1;

    logic              clk = 1'b0;
    logic              wrst = 1'b0;
    logic [NC-1:0]     winc = '0;
    logic [NC-1:0]     rinc = '0;
    logic [NC*DW-1:0]  wdata = '0;
    logic              err_clr = 1'b0;
    logic [NC*DW-1:0]  rd_s, rd_f;
    logic [NC-1:0]     full_s, empty_s, afull_s, aempty_s, ovf_s, udf_s;
    logic [NC-1:0]     full_f, empty_f, afull_f, aempty_f, ovf_f, udf_f;
    logic [NC*(AW+1)-1:0] lvl_s, lvl_f;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mq [NC][$];
    logic [DW-1:0] sb [NC][$];
    logic [DW-1:0] hold [NC];
    logic          m_ovf [NC];
    logic          m_udf [NC];

    always #5 clk = ~clk;

    async_fifo_mc_bank #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .NCH(NC), .AFULL_TH(AF),
                         .AEMPTY_TH(AE), .FWFT(0)) dut (
        .rclk(clk), .wrst(wrst), .winc(winc), .wData(wdata), .rinc(rinc), .rData(rd_s),
        .wFull(full_s), .rEmpty(empty_s), .aFull(afull_s), .aEmpty(aempty_s), .level(lvl_s),
        .ovf(ovf_s), .udf(udf_s), .err_clr(err_clr));

    async_fifo_mc_bank #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .NCH(NC), .AFULL_TH(AF),
                         .AEMPTY_TH(AE), .FWFT(1)) dut_fw (
        .rclk(clk), .wrst(wrst), .winc(winc), .wData(wdata), .rinc(rinc), .rData(rd_f),
        .wFull(full_f), .rEmpty(empty_f), .aFull(afull_f), .aEmpty(aempty_f), .level(lvl_f),
        .ovf(ovf_f), .udf(udf_f), .err_clr(err_clr));

    task automatic chk(input string nm, input int c, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s ch%0d got %0h expected %0h at %0t", nm, c, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NC; c++) begin
            mq[c].delete();
            sb[c].delete();
            hold[c] = '0;
            m_ovf[c] = 1'b0;
            m_udf[c] = 1'b0;
        end
    endtask

    // Drive one cycle of stimulus and advance the reference model to its post-edge state.
    task automatic step(input logic [NC-1:0] w, input logic [NC-1:0] r,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic clr);
        logic [DW-1:0] d [NC];
        int lvl;
        @(negedge clk);
        winc = w; rinc = r; wdata = {d1, d0}; err_clr = clr;
        d[0] = d0; d[1] = d1;
        for (int c = 0; c < NC; c++) begin
            lvl = mq[c].size();
            if (w[c] && lvl == DEPTH) m_ovf[c] = 1'b1; else if (clr) m_ovf[c] = 1'b0;
            if (r[c] && lvl == 0)     m_udf[c] = 1'b1; else if (clr) m_udf[c] = 1'b0;
            if (r[c] && lvl > 0) sb[c].push_back(mq[c].pop_front());
            if (w[c] && lvl < DEPTH) mq[c].push_back(d[c]);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        wrst = 1'b0;
        winc = '0; rinc = '0; err_clr = 1'b0;
        model_clear();
        repeat (n) @(negedge clk);
        wrst = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        for (int c = 0; c < NC; c++) begin
            int n;
            n = mq[c].size();
            if (sb[c].size() > 0) hold[c] = sb[c].pop_front();
            chk("rdata_std", c, int'(rd_s[c*DW +: DW]), int'(hold[c]));
            chk("rdata_fwft", c, int'(rd_f[c*DW +: DW]), (n > 0) ? int'(mq[c][0]) : 0);
            chk("level", c, int'(lvl_s[c*(AW+1) +: AW+1]), n);
            chk("level_fwft", c, int'(lvl_f[c*(AW+1) +: AW+1]), n);
            chk("wfull", c, int'(full_s[c]), int'(n == DEPTH));
            chk("rempty", c, int'(empty_s[c]), int'(n == 0));
            chk("afull", c, int'(afull_s[c]), int'(n >= AF));
            chk("aempty", c, int'(aempty_s[c]), int'(n <= AE));
            chk("ovf", c, int'(ovf_s[c]), int'(m_ovf[c]));
            chk("udf", c, int'(udf_s[c]), int'(m_udf[c]));
            chk("flags_fwft", c, int'({full_f[c], empty_f[c], afull_f[c], aempty_f[c], ovf_f[c], udf_f[c]}),
                int'({n == DEPTH, n == 0, n >= AF, n <= AE, m_ovf[c], m_udf[c]}));
        end
    end

    initial begin
        model_clear();
        repeat (3) @(negedge clk);
        wrst = 1'b1;
        // Fill ch0 to full, then one rejected push.
        for (int i = 1; i <= 5; i++) step(2'b01, 2'b00, DW'(i), '0, 1'b0);
        // Drain ch0, one rejected pop, then clear the sticky errors.
        for (int i = 0; i < 5; i++) step(2'b00, 2'b01, '0, '0, 1'b0);
        step(2'b00, 2'b00, '0, '0, 1'b1);
        // Streaming through both channels so the pointers wrap past 2*DEPTH.
        step(2'b11, 2'b00, 12'h100, 12'h200, 1'b0);
        for (int i = 1; i < 10; i++) step(2'b11, 2'b11, DW'(12'h100 + i), DW'(12'h200 + i), 1'b0);
        step(2'b00, 2'b11, '0, '0, 1'b0);
        // Simultaneous push/pop at full, then at empty.
        for (int i = 0; i < 4; i++) step(2'b01, 2'b00, DW'(12'h300 + i), '0, 1'b0);
        step(2'b01, 2'b01, 12'h3FF, '0, 1'b0);
        for (int i = 0; i < 3; i++) step(2'b00, 2'b01, '0, '0, 1'b0);
        step(2'b01, 2'b01, 12'h555, '0, 1'b0);
        step(2'b00, 2'b00, '0, '0, 1'b0);
        step(2'b00, 2'b01, '0, '0, 1'b1);
        // Single word into empty ch1, observed without a pop, then popped.
        step(2'b10, 2'b00, '0, 12'hABC, 1'b0);
        step(2'b00, 2'b00, '0, '0, 1'b0);
        step(2'b00, 2'b10, '0, '0, 1'b0);
        step(2'b00, 2'b00, '0, '0, 1'b0);
        // Random traffic with a reset in the middle.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset(2);
            step(2'($urandom), 2'($urandom), DW'($urandom), DW'($urandom), ($urandom_range(0, 15) == 0));
        end
        step(2'b00, 2'b00, '0, '0, 1'b0);
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
